// File: rtl/spi_flash_cmd.sv
// spi_flash_cmd: generic SPI-flash command engine (SPI mode 0).
// Sends an 8-bit opcode, then an optional 24-bit address, then clocks in
// 0..MAX_RX bytes. Each received byte is streamed out with an rx_valid pulse.
// Optional feature macro: SPI_RDID_CAPTURE_EN. When it is defined, the engine
// keeps the first three bytes of every 0x9F (RDID) command in ID registers.
// Timing reference: the cycle in which start is sampled is cycle 0.
module spi_flash_cmd #(
  parameter int CLK_DIV = 2,
  parameter int MAX_RX  = 16,
  parameter int CS_GAP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  opcode,
  input  logic [23:0] addr,
  input  logic        addr_en,
  input  logic [7:0]  rx_len,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        SPIMISO,
  output logic        SPICLK,
  output logic        SPIMOSI,
  output logic        cs_prom_n
`ifdef SPI_RDID_CAPTURE_EN
  ,
  output logic [7:0]  manufacture_id,
  output logic [7:0]  memory_type,
  output logic [7:0]  memory_capacity
`endif
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);
  localparam logic [7:0]  MAX_RX_B = 8'(MAX_RX);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_GAP      = 3'd4
  } state_t;

  state_t       state_r;
  state_t       state_nxt_s;

  logic [15:0]  div_cnt_r;
  logic [15:0]  gap_cnt_r;
  logic [11:0]  bit_cnt_r;
  logic [11:0]  last_bit_r;
  logic [11:0]  tx_bits_r;
  logic [30:0]  tx_sr_r;      // bits still to send after the one on MOSI
  logic [7:0]   rx_sr_r;
  logic         byte_rdy_r;

  logic         busy_r;
  logic         done_r;
  logic         cs_n_r;
  logic         sclk_r;
  logic         mosi_r;
  logic [7:0]   rx_data_r;
  logic         rx_valid_r;

  logic         div_tick_s;
  logic         gap_end_s;
  logic         start_ok_s;
  logic         last_bit_s;
  logic         rise_s;
  logic         fall_s;
  logic [7:0]   rx_clamp_s;
  logic [11:0]  hdr_bits_s;
  logic [11:0]  bits_total_s;
  logic [31:0]  tx_load_s;

  // Command decode: clamp the receive length and build the transmit header.
  always_comb begin
    rx_clamp_s   = rx_len;
    hdr_bits_s   = 12'd8;
    tx_load_s    = {opcode, 24'h000000};
    if (rx_len > MAX_RX_B) begin
      rx_clamp_s = MAX_RX_B;
    end else begin
      rx_clamp_s = rx_len;
    end
    if (addr_en) begin
      tx_load_s  = {opcode, addr};
      hdr_bits_s = 12'd32;
    end else begin
      tx_load_s  = {opcode, 24'h000000};
      hdr_bits_s = 12'd8;
    end
    bits_total_s = hdr_bits_s + {1'b0, rx_clamp_s, 3'b000};
  end

  // Next-state logic plus the SPICLK edge strobes for the datapath.
  always_comb begin
    state_nxt_s = state_r;
    div_tick_s  = (div_cnt_r == DIV_LAST);
    gap_end_s   = (gap_cnt_r == GAP_LAST);
    // The done cycle is still blocked so a new command needs a fresh cycle.
    start_ok_s  = start && !busy_r && !done_r;
    last_bit_s  = (bit_cnt_r == last_bit_r);
    rise_s      = 1'b0;
    fall_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_nxt_s = ST_CS_SETUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CS_SETUP: begin
        if (div_tick_s) begin
          state_nxt_s = ST_SHIFT;
          rise_s      = 1'b1;
        end else begin
          state_nxt_s = ST_CS_SETUP;
        end
      end
      ST_SHIFT: begin
        if (div_tick_s) begin
          if (sclk_r) begin
            fall_s = 1'b1;
            if (last_bit_s) begin
              state_nxt_s = ST_CS_HOLD;
            end else begin
              state_nxt_s = ST_SHIFT;
            end
          end else begin
            rise_s      = 1'b1;
            state_nxt_s = ST_SHIFT;
          end
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_CS_HOLD: begin
        if (div_tick_s) begin
          state_nxt_s = ST_GAP;
        end else begin
          state_nxt_s = ST_CS_HOLD;
        end
      end
      ST_GAP: begin
        if (gap_end_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Half-period divider for SPICLK and the post-command CS gap counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_r <= 16'd0;
      gap_cnt_r <= 16'd0;
    end else begin
      if ((state_r == ST_CS_SETUP) || (state_r == ST_SHIFT) || (state_r == ST_CS_HOLD)) begin
        if (div_tick_s) begin
          div_cnt_r <= 16'd0;
        end else begin
          div_cnt_r <= div_cnt_r + 16'd1;
        end
      end else begin
        div_cnt_r <= 16'd0;
      end
      if (state_r == ST_GAP) begin
        gap_cnt_r <= gap_cnt_r + 16'd1;
      end else begin
        gap_cnt_r <= 16'd0;
      end
    end
  end

  // Command framing: busy, chip select and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      cs_n_r <= 1'b1;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if ((state_r == ST_IDLE) && start_ok_s) begin
        busy_r <= 1'b1;
        cs_n_r <= 1'b0;
      end else if ((state_r == ST_CS_HOLD) && div_tick_s) begin
        cs_n_r <= 1'b1;
      end else if ((state_r == ST_GAP) && gap_end_s) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end
    end
  end

  // Transmit side: latch the command, drive SPICLK, and shift MOSI on the falling edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b0;
      tx_sr_r    <= 31'd0;
      bit_cnt_r  <= 12'd0;
      last_bit_r <= 12'd0;
      tx_bits_r  <= 12'd8;
    end else if ((state_r == ST_IDLE) && start_ok_s) begin
      sclk_r     <= 1'b0;
      mosi_r     <= tx_load_s[31];
      tx_sr_r    <= tx_load_s[30:0];
      bit_cnt_r  <= 12'd0;
      last_bit_r <= bits_total_s - 12'd1;
      tx_bits_r  <= hdr_bits_s;
    end else if (rise_s) begin
      sclk_r <= 1'b1;
    end else if (fall_s) begin
      sclk_r    <= 1'b0;
      bit_cnt_r <= bit_cnt_r + 12'd1;
      if (last_bit_s) begin
        mosi_r  <= 1'b0;
        tx_sr_r <= 31'd0;
      end else begin
        // Header shifting drains to zeros, so MOSI stays 0 during receive.
        mosi_r  <= tx_sr_r[30];
        tx_sr_r <= {tx_sr_r[29:0], 1'b0};
      end
    end
  end

  // Receive side: sample MISO on rising edges and publish each byte one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sr_r    <= 8'd0;
      byte_rdy_r <= 1'b0;
      rx_data_r  <= 8'd0;
      rx_valid_r <= 1'b0;
    end else begin
      byte_rdy_r <= 1'b0;
      rx_valid_r <= 1'b0;
      if (rise_s && (bit_cnt_r >= tx_bits_r)) begin
        rx_sr_r    <= {rx_sr_r[6:0], SPIMISO};
        byte_rdy_r <= (bit_cnt_r[2:0] == 3'd7);
      end
      if (byte_rdy_r) begin
        rx_data_r  <= rx_sr_r;
        rx_valid_r <= 1'b1;
      end
    end
  end

`ifdef SPI_RDID_CAPTURE_EN
  logic         is_rdid_r;
  logic [7:0]   rx_idx_r;
  logic [7:0]   mfg_id_r;
  logic [7:0]   mem_type_r;
  logic [7:0]   mem_cap_r;

  // RDID capture: the first three bytes of a 0x9F command refresh the ID registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_rdid_r  <= 1'b0;
      rx_idx_r   <= 8'd0;
      mfg_id_r   <= 8'd0;
      mem_type_r <= 8'd0;
      mem_cap_r  <= 8'd0;
    end else if ((state_r == ST_IDLE) && start_ok_s) begin
      is_rdid_r <= (opcode == 8'h9F);
      rx_idx_r  <= 8'd0;
    end else if (byte_rdy_r) begin
      rx_idx_r <= rx_idx_r + 8'd1;
      if (is_rdid_r) begin
        case (rx_idx_r)
          8'd0:    mfg_id_r   <= rx_sr_r;
          8'd1:    mem_type_r <= rx_sr_r;
          8'd2:    mem_cap_r  <= rx_sr_r;
          default: mfg_id_r   <= mfg_id_r;
        endcase
      end
    end
  end

  assign manufacture_id  = mfg_id_r;
  assign memory_type     = mem_type_r;
  assign memory_capacity = mem_cap_r;
`endif

  assign busy      = busy_r;
  assign done      = done_r;
  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign SPICLK    = sclk_r;
  assign SPIMOSI   = mosi_r;
  assign cs_prom_n = cs_n_r;

endmodule

// File: tb/tb_spi_flash_cmd.sv
// Bench for spi_flash_cmd: one instance with CLK_DIV=2 and one with CLK_DIV=1.
// A flash model serves MISO bytes from a response table. Expected receive bytes
// are queued in a scoreboard when a command is launched and popped on rx_valid.
module tb_spi_flash_cmd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start0, start1;
  logic [7:0]  opcode;
  logic [23:0] addr;
  logic        addr_en;
  logic [7:0]  rx_len;

  logic        busy0, done0, rxv0, miso0, sclk0, mosi0, cs0;
  logic        busy1, done1, rxv1, miso1, sclk1, mosi1, cs1;
  logic [7:0]  rxd0, rxd1;
`ifdef SPI_RDID_CAPTURE_EN
  logic [7:0]  mid0, mt0, mc0, mid1, mt1, mc1;
`endif

  spi_flash_cmd #(.CLK_DIV(2), .MAX_RX(16), .CS_GAP(4)) dut (
    .clk(clk), .reset(reset), .start(start0), .opcode(opcode), .addr(addr),
    .addr_en(addr_en), .rx_len(rx_len), .busy(busy0), .done(done0),
    .rx_data(rxd0), .rx_valid(rxv0), .SPIMISO(miso0), .SPICLK(sclk0),
    .SPIMOSI(mosi0), .cs_prom_n(cs0)
`ifdef SPI_RDID_CAPTURE_EN
    , .manufacture_id(mid0), .memory_type(mt0), .memory_capacity(mc0)
`endif
  );

  spi_flash_cmd #(.CLK_DIV(1), .MAX_RX(16), .CS_GAP(4)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .opcode(opcode), .addr(addr),
    .addr_en(addr_en), .rx_len(rx_len), .busy(busy1), .done(done1),
    .rx_data(rxd1), .rx_valid(rxv1), .SPIMISO(miso1), .SPICLK(sclk1),
    .SPIMOSI(mosi1), .cs_prom_n(cs1)
`ifdef SPI_RDID_CAPTURE_EN
    , .manufacture_id(mid1), .memory_type(mt1), .memory_capacity(mc1)
`endif
  );

  logic [1:0] busy_v, done_v, rxv_v, sclk_v, cs_v;
  assign busy_v = {busy1, busy0};
  assign done_v = {done1, done0};
  assign rxv_v  = {rxv1, rxv0};
  assign sclk_v = {sclk1, sclk0};
  assign cs_v   = {cs1, cs0};

  logic [7:0] resp [0:299];
  logic [7:0] mb0  [0:299];
  logic [7:0] mb1  [0:299];
  int         rise0, rise1;
  logic [7:0] sb [$];
  int         n_vec, n_err;

  // Flash model, instance 0: count rises since CS fell and log MOSI per bit.
  always @(posedge sclk0 or negedge cs0) begin
    if (sclk0) begin
      if (rise0 < 2400) mb0[rise0 / 8][7 - (rise0 % 8)] = mosi0;
      rise0 = rise0 + 1;
    end else begin
      rise0 = 0;
    end
  end

  // Flash model, instance 1.
  always @(posedge sclk1 or negedge cs1) begin
    if (sclk1) begin
      if (rise1 < 2400) mb1[rise1 / 8][7 - (rise1 % 8)] = mosi1;
      rise1 = rise1 + 1;
    end else begin
      rise1 = 0;
    end
  end

  // MISO presents bit k of the response table before rise k.
  always_comb begin
    miso0 = 1'b0;
    miso1 = 1'b0;
    if (rise0 < 2400) miso0 = resp[rise0 / 8][7 - (rise0 % 8)];
    if (rise1 < 2400) miso1 = resp[rise1 / 8][7 - (rise1 % 8)];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mosi_byte(input int d, input int i);
    return (d == 0) ? mb0[i] : mb1[i];
  endfunction

  task automatic set_start(input int d, input logic v);
    if (d == 0) start0 = v;
    else        start1 = v;
  endtask

  // Launch one command on instance d and check framing, timing and data.
  task automatic run_cmd(input int d, input logic [7:0] op, input logic [23:0] a,
                         input logic ae, input logic [7:0] rl,
                         input int intr_at, input bit poke_done);
    int div, clamp, hdr, nbits, exp_cs, exp_done;
    int cs_cyc, done_cyc, n_done, n_rx, sclk_bad, nr;
    logic [7:0] expb, acc;
    div      = (d == 0) ? 2 : 1;
    clamp    = (rl > 8'd16) ? 16 : int'(rl);
    hdr      = ae ? 4 : 1;
    nbits    = 8 * (hdr + clamp);
    exp_cs   = 1 + 2 * nbits * div + div;
    exp_done = exp_cs + 4;
    for (int i = 0; i < 300; i++) resp[i] = 8'($urandom_range(0, 255));
    if (op == 8'h9F) begin
      resp[1] = 8'h20; resp[2] = 8'hBA; resp[3] = 8'h18;
    end
    for (int j = 0; j < clamp; j++) sb.push_back(resp[hdr + j]);
    cs_cyc = 0; done_cyc = 0; n_done = 0; n_rx = 0; sclk_bad = 0;
    @(negedge clk);
    opcode = op; addr = a; addr_en = ae; rx_len = rl;
    set_start(d, 1'b1);
    @(posedge clk);
    for (int t = 1; t < 3000; t++) begin
      @(negedge clk);
      set_start(d, 1'b0);
      opcode = op;
      if (t == 1) begin
        check_eq("busy_cycle1", busy_v[d], 1'b1);
        check_eq("cs_low_cycle1", cs_v[d], 1'b0);
      end
      if (cs_v[d] && sclk_v[d]) sclk_bad++;
      if (cs_v[d] && (cs_cyc == 0) && (t > 1)) cs_cyc = t;
      if (rxv_v[d]) begin
        n_rx++;
        if (sb.size() == 0) begin
          check_eq("rx_extra", 1, 0);
        end else begin
          expb = sb.pop_front();
          check_eq("rx_data", (d == 0) ? rxd0 : rxd1, expb);
        end
      end
      if (done_v[d]) begin
        n_done++;
        if (done_cyc == 0) begin
          done_cyc = t;
          check_eq("busy_low_at_done", busy_v[d], 1'b0);
          if (poke_done) set_start(d, 1'b1);
        end
      end
      if (poke_done && (done_cyc != 0) && (t == done_cyc + 1)) begin
        check_eq("start_at_done_ignored_busy", busy_v[d], 1'b0);
        check_eq("start_at_done_ignored_cs", cs_v[d], 1'b1);
      end
      if (t == intr_at) begin
        set_start(d, 1'b1);
        opcode = 8'h5A;
      end
      if ((done_cyc != 0) && (t >= done_cyc + 4)) break;
    end
    nr = (d == 0) ? rise0 : rise1;
    check_eq("cs_rise_cycle", cs_cyc, exp_cs);
    check_eq("done_cycle", done_cyc, exp_done);
    check_eq("done_count", n_done, 1);
    check_eq("sclk_rises", nr, nbits);
    check_eq("sclk_high_with_cs_high", sclk_bad, 0);
    check_eq("rx_count", n_rx, clamp);
    check_eq("sb_empty", sb.size(), 0);
    sb.delete();
    check_eq("mosi_opcode", mosi_byte(d, 0), op);
    if (ae) check_eq("mosi_addr", {mosi_byte(d, 1), mosi_byte(d, 2), mosi_byte(d, 3)}, a);
    acc = 8'h00;
    for (int i = hdr; i < hdr + clamp; i++) acc = acc | mosi_byte(d, i);
    check_eq("mosi_zero_in_rx", acc, 8'h00);
  endtask

  // Abort an RDID during bit 10 with reset and check the immediate abort.
  task automatic reset_mid();
    int n_bad, t_hit;
    for (int i = 0; i < 300; i++) resp[i] = 8'($urandom_range(0, 255));
    n_bad = 0; t_hit = 0;
    @(negedge clk);
    opcode = 8'h9F; addr = 24'h0; addr_en = 1'b0; rx_len = 8'd3;
    start0 = 1'b1;
    @(posedge clk);
    for (int t = 1; t < 500; t++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (done0 || rxv0) n_bad++;
      if (rise0 >= 11) begin
        t_hit = t;
        break;
      end
    end
    check_eq("reset_reached_bit10", (t_hit != 0), 1'b1);
    check_eq("sclk_high_before_reset", sclk0, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_cs", cs0, 1'b1);
    check_eq("abort_sclk", sclk0, 1'b0);
    check_eq("abort_busy", busy0, 1'b0);
    check_eq("abort_done", done0, 1'b0);
    reset = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (done0 || rxv0 || !cs0) n_bad++;
    end
    check_eq("abort_quiet", n_bad, 0);
`ifdef SPI_RDID_CAPTURE_EN
    check_eq("id_after_reset", {mid0, mt0, mc0}, 24'h000000);
`endif
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
    opcode = 8'h00; addr = 24'h0; addr_en = 1'b0; rx_len = 8'd0;
    for (int i = 0; i < 300; i++) resp[i] = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", busy0, 1'b0);
    check_eq("rst_done", done0, 1'b0);
    check_eq("rst_rx_valid", rxv0, 1'b0);
    check_eq("rst_rx_data", rxd0, 8'h00);
    check_eq("rst_sclk", sclk0, 1'b0);
    check_eq("rst_mosi", mosi0, 1'b0);
    check_eq("rst_cs", cs0, 1'b1);
`ifdef SPI_RDID_CAPTURE_EN
    check_eq("rst_id", {mid0, mt0, mc0}, 24'h000000);
`endif

    run_cmd(0, 8'h9F, 24'h000000, 1'b0, 8'd3, 0, 1'b0);
`ifdef SPI_RDID_CAPTURE_EN
    check_eq("rdid_capture", {mid0, mt0, mc0}, 24'h20BA18);
`endif
    run_cmd(0, 8'h03, 24'h123456, 1'b1, 8'd2, 0, 1'b0);
`ifdef SPI_RDID_CAPTURE_EN
    check_eq("id_hold_non_rdid", {mid0, mt0, mc0}, 24'h20BA18);
`endif
    run_cmd(0, 8'h06, 24'h000000, 1'b0, 8'd0, 0, 1'b1);
    run_cmd(0, 8'h0B, 24'($urandom), 1'b1, 8'd200, 0, 1'b0);
    run_cmd(0, 8'h9F, 24'h000000, 1'b0, 8'd3, 40, 1'b0);
    reset_mid();
    run_cmd(0, 8'h9F, 24'h000000, 1'b0, 8'd3, 0, 1'b0);
`ifdef SPI_RDID_CAPTURE_EN
    check_eq("rdid_recapture", {mid0, mt0, mc0}, 24'h20BA18);
`endif
    run_cmd(1, 8'h9F, 24'h000000, 1'b0, 8'd3, 0, 1'b0);
`ifdef SPI_RDID_CAPTURE_EN
    check_eq("rdid_capture_div1", {mid1, mt1, mc1}, 24'h20BA18);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
